// File: rtl/sync_fifo_flex.sv
// Parametrised synchronous FIFO for serialized pixel/feature streams.
// Selectable read mode: FWFT=0 gives a registered read (rd_valid pulses one
// cycle after an accepted rd_en); FWFT=1 adds a show-ahead output stage whose
// word is visible while rd_valid is high and is popped by rd_en.
// Handshake: a write is accepted when wr_en=1 and full=0; a read/pop is
// accepted when rd_en=1 and a word is available (empty=0 for FWFT=0,
// rd_valid=1 for FWFT=1). Refused requests set the sticky overflow/underflow
// flags, which clear only on rst or flush.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0]         AE_C     = CW'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         cnt;      // words held in mem (excludes the FWFT output stage)

  logic                  wr_do;
  logic                  mem_rd;   // a word leaves mem into rd_data this edge
  logic                  rd_err;
  logic                  rv_n;
  logic [CW-1:0]         cnt_n;
  logic [CW-1:0]         lvl_n;
  logic                  empty_n;
  logic                  full_n;

  // Next-state of count, output stage and status; all status is registered from these.
  always_comb begin
    wr_do  = wr_en & ~full;
    mem_rd = 1'b0;
    rv_n   = 1'b0;
    rd_err = 1'b0;
    if (FWFT != 0) begin
      // Refill the output stage whenever it is empty or being popped.
      mem_rd = (cnt != '0) & (~rd_valid | rd_en);
      rv_n   = mem_rd | (rd_valid & ~rd_en);
      rd_err = rd_en & ~rd_valid;
    end else begin
      mem_rd = rd_en & ~empty;
      rv_n   = mem_rd;
      rd_err = rd_en & empty;
    end
    cnt_n = cnt;
    if (wr_do & ~mem_rd)
      cnt_n = cnt + CW'(1);
    else if (~wr_do & mem_rd)
      cnt_n = cnt - CW'(1);
    if (FWFT != 0) begin
      lvl_n   = cnt_n + CW'(rv_n);
      empty_n = ~rv_n;
    end else begin
      lvl_n   = cnt_n;
      empty_n = (cnt_n == '0);
    end
    full_n = (cnt_n == DEPTH_C);
  end

  // Storage array: no reset, written only on accepted writes outside a flush.
  always_ff @(posedge clk) begin
    if (wr_do & ~flush)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers, count, output register, status and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      level        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      level        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_do)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (mem_rd) begin
        rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      cnt          <= cnt_n;
      rd_valid     <= rv_n;
      full         <= full_n;
      empty        <= empty_n;
      almost_full  <= (lvl_n >= AF_C);
      almost_empty <= (lvl_n <= AE_C);
      level        <= lvl_n;
      if (wr_en & full)
        overflow <= 1'b1;
      if (rd_err)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: three instances share one stimulus stream
//   d0: FWFT=0, DEPTH=8   d1: FWFT=1, DEPTH=8   d2: FWFT=0, DEPTH=6
// Each instance is tracked by a queue-based reference model.
module tb_sync_fifo_flex;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;

  logic [15:0] d0_rd_data, d1_rd_data, d2_rd_data;
  logic        d0_rv, d1_rv, d2_rv;
  logic        d0_full, d1_full, d2_full;
  logic        d0_empty, d1_empty, d2_empty;
  logic        d0_af, d1_af, d2_af;
  logic        d0_ae, d1_ae, d2_ae;
  logic [3:0]  d0_level, d1_level, d2_level;
  logic        d0_ov, d1_ov, d2_ov;
  logic        d0_un, d1_un, d2_un;

  int tests;
  int failed;

  // reference model state
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic        m0_rv, m0_ov, m0_un;
  logic [15:0] m0_rd;
  logic        m1_v, m1_ov, m1_un;
  logic [15:0] m1_d;
  logic        m2_rv, m2_ov, m2_un;
  logic [15:0] m2_rd;

  sync_fifo_flex #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .FWFT(0),
                   .AF_THRESH(4), .AE_THRESH(2)) d0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(d0_rd_data), .rd_valid(d0_rv), .full(d0_full),
    .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .level(d0_level), .overflow(d0_ov), .underflow(d0_un));

  sync_fifo_flex #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3), .FWFT(1),
                   .AF_THRESH(6), .AE_THRESH(1)) d1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(d1_rd_data), .rd_valid(d1_rv), .full(d1_full),
    .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .level(d1_level), .overflow(d1_ov), .underflow(d1_un));

  sync_fifo_flex #(.DATA_WIDTH(16), .DEPTH(6), .ADDR_WIDTH(3), .FWFT(0),
                   .AF_THRESH(5), .AE_THRESH(1)) d2 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(d2_rd_data), .rd_valid(d2_rv), .full(d2_full),
    .empty(d2_empty), .almost_full(d2_af), .almost_empty(d2_ae),
    .level(d2_level), .overflow(d2_ov), .underflow(d2_un));

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    m0_rv = 0; m0_ov = 0; m0_un = 0; m0_rd = '0;
    m1_v  = 0; m1_ov = 0; m1_un = 0; m1_d  = '0;
    m2_rv = 0; m2_ov = 0; m2_un = 0; m2_rd = '0;
  endtask

  // Behavioural rules applied once per clock edge.
  task automatic model_step(input logic we, input logic re, input logic [15:0] wd,
                            input logic fl);
    logic wok, rok;
    if (fl) begin
      model_reset();
      return;
    end
    // d0: registered read, depth 8
    wok = we && (q0.size() < 8);
    rok = re && (q0.size() > 0);
    m0_rv = rok;
    if (rok) m0_rd = q0.pop_front();
    if (re && !rok) m0_un = 1;
    if (we && !wok) m0_ov = 1;
    if (wok) q0.push_back(wd);
    // d2: registered read, depth 6
    wok = we && (q2.size() < 6);
    rok = re && (q2.size() > 0);
    m2_rv = rok;
    if (rok) m2_rd = q2.pop_front();
    if (re && !rok) m2_un = 1;
    if (we && !wok) m2_ov = 1;
    if (wok) q2.push_back(wd);
    // d1: show-ahead, depth 8 memory plus one output word
    wok = we && (q1.size() < 8);
    if (re && !m1_v) m1_un = 1;
    if (we && !wok) m1_ov = 1;
    if ((q1.size() > 0) && (!m1_v || re)) begin
      m1_d = q1.pop_front();
      m1_v = 1;
    end else if (re && m1_v) begin
      m1_v = 0;
    end
    if (wok) q1.push_back(wd);
  endtask

  // driver: apply one cycle of inputs, advance model, leave outputs settled
  task automatic tick(input logic we, input logic re, input logic [15:0] wd,
                      input logic fl);
    wr_en = we; rd_en = re; wr_data = wd; flush = fl;
    @(posedge clk);
    model_step(we, re, wd, fl);
    #1;
    wr_en = 0; rd_en = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 0; rd_en = 0; flush = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    tests++;
    if ({d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un} !== 7'b0010100) begin
      failed++;
      $display("FAIL reset_status_d0: got %b exp 0010100",
               {d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un});
    end
    tests++;
    if (d0_level !== 4'd0 || d0_rd_data !== 16'h0) begin
      failed++;
      $display("FAIL reset_level_data_d0: got level %0d data %h exp 0 0000", d0_level, d0_rd_data);
    end
    tests++;
    if (d1_rv !== 1'b0 || d1_empty !== 1'b1 || d1_level !== 4'd0) begin
      failed++;
      $display("FAIL reset_d1: got rv %b empty %b level %0d exp 0 1 0", d1_rv, d1_empty, d1_level);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 16'h10 + 16'(i), 0);
      tests++;
      if (d0_level !== 4'(i) || d0_af !== (i >= 4) || d0_full !== (i == 8)) begin
        failed++;
        $display("FAIL fill_%0d: got level %0d af %b full %b exp level %0d af %b full %b",
                 i, d0_level, d0_af, d0_full, i, (i >= 4), (i == 8));
      end
    end
    tick(1, 0, 16'h0099, 0);
    tests++;
    if (d0_ov !== 1'b1 || d0_level !== 4'd8) begin
      failed++;
      $display("FAIL overflow_write: got ov %b level %0d exp 1 8", d0_ov, d0_level);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, '0, 0);
      tests++;
      if (d0_rv !== 1'b1 || d0_rd_data !== 16'h11 + 16'(i)) begin
        failed++;
        $display("FAIL drain_%0d: got rv %b data %h exp 1 %h", i, d0_rv, d0_rd_data, 16'h11 + 16'(i));
      end
    end
    tick(0, 0, '0, 0);
    tests++;
    if (d0_rv !== 1'b0 || d0_rd_data !== 16'h0018 || d0_empty !== 1'b1) begin
      failed++;
      $display("FAIL drain_idle: got rv %b data %h empty %b exp 0 0018 1", d0_rv, d0_rd_data, d0_empty);
    end
  endtask

  task automatic test_underflow_flush();
    tick(0, 1, '0, 0);
    tests++;
    if (d0_un !== 1'b1 || d0_rv !== 1'b0) begin
      failed++;
      $display("FAIL underflow_read: got un %b rv %b exp 1 0", d0_un, d0_rv);
    end
    tick(1, 1, 16'h5555, 1);
    tests++;
    if (d0_un !== 1'b0 || d0_ov !== 1'b0 || d0_empty !== 1'b1 || d0_level !== 4'd0) begin
      failed++;
      $display("FAIL flush_clear: got un %b ov %b empty %b level %0d exp 0 0 1 0",
               d0_un, d0_ov, d0_empty, d0_level);
    end
  endtask

  task automatic test_fwft();
    logic [15:0] exp_w;
    int stalls;
    tick(1, 0, 16'hABCD, 0);
    tests++;
    if (d1_rv !== 1'b0) begin
      failed++;
      $display("FAIL fwft_no_bypass: got rv %b exp 0", d1_rv);
    end
    tick(0, 0, '0, 0);
    tests++;
    if (d1_rv !== 1'b1 || d1_rd_data !== 16'hABCD || d1_level !== 4'd1) begin
      failed++;
      $display("FAIL fwft_show: got rv %b data %h level %0d exp 1 abcd 1", d1_rv, d1_rd_data, d1_level);
    end
    tick(0, 1, '0, 0);
    tests++;
    if (d1_empty !== 1'b1 || d1_level !== 4'd0) begin
      failed++;
      $display("FAIL fwft_pop: got empty %b level %0d exp 1 0", d1_empty, d1_level);
    end
    tick(0, 0, '0, 1);
    exp_w = 0;
    stalls = 0;
    for (int k = 0; k < 100; k++) begin
      if (d1_rv) begin
        tests++;
        if (d1_rd_data !== exp_w) begin
          failed++;
          $display("FAIL fwft_stream_data: got %h exp %h", d1_rd_data, exp_w);
        end
        exp_w++;
      end else if (k >= 2) begin
        stalls++;
      end
      tick(1, 1, 16'(k), 0);
    end
    for (int k = 0; k < 20 && d1_rv; k++) begin
      tests++;
      if (d1_rd_data !== exp_w) begin
        failed++;
        $display("FAIL fwft_drain_data: got %h exp %h", d1_rd_data, exp_w);
      end
      exp_w++;
      tick(0, 1, '0, 0);
    end
    tests++;
    if (exp_w !== 16'd100 || stalls != 0) begin
      failed++;
      $display("FAIL fwft_stream_rate: got words %0d stalls %0d exp 100 0", exp_w, stalls);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_w;
    tick(0, 0, '0, 1);
    for (int k = 0; k < 3; k++) tick(1, 0, 16'h100 + 16'(k), 0);
    exp_w = 16'h100;
    for (int k = 3; k < 23; k++) begin
      tick(1, 1, 16'h100 + 16'(k), 0);
      tests++;
      if (d2_rv !== 1'b1 || d2_rd_data !== exp_w || d2_level !== 4'd3 ||
          d2_ov !== 1'b0 || d2_un !== 1'b0) begin
        failed++;
        $display("FAIL wrap_%0d: got rv %b data %h level %0d ov %b un %b exp 1 %h 3 0 0",
                 k, d2_rv, d2_rd_data, d2_level, d2_ov, d2_un, exp_w);
      end
      exp_w++;
    end
  endtask

  task automatic test_simultaneous();
    tick(0, 0, '0, 1);
    for (int k = 0; k < 8; k++) tick(1, 0, 16'h200 + 16'(k), 0);
    tick(1, 1, 16'h2FF, 0);
    tests++;
    if (d0_level !== 4'd7 || d0_ov !== 1'b1 || d0_rv !== 1'b1 || d0_rd_data !== 16'h0200) begin
      failed++;
      $display("FAIL simul_full: got level %0d ov %b rv %b data %h exp 7 1 1 0200",
               d0_level, d0_ov, d0_rv, d0_rd_data);
    end
    tick(0, 0, '0, 1);
    tick(1, 1, 16'h3333, 0);
    tests++;
    if (d0_level !== 4'd1 || d0_un !== 1'b1 || d0_rv !== 1'b0) begin
      failed++;
      $display("FAIL simul_empty: got level %0d un %b rv %b exp 1 1 0", d0_level, d0_un, d0_rv);
    end
  endtask

  task automatic test_random();
    logic we, re, fl;
    int lvl1;
    tick(0, 0, '0, 1);
    for (int n = 0; n < 600; n++) begin
      // phases bias toward filling, then draining, then mixed traffic
      if (n < 150)      begin we = ($urandom_range(0, 99) < 80); re = ($urandom_range(0, 99) < 30); end
      else if (n < 300) begin we = ($urandom_range(0, 99) < 25); re = ($urandom_range(0, 99) < 80); end
      else              begin we = ($urandom_range(0, 1) == 1);  re = ($urandom_range(0, 1) == 1);  end
      fl = ($urandom_range(0, 149) == 0);
      tick(we, re, 16'($urandom), fl);
      tests++;
      if ({d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un, d0_rv} !==
          {q0.size() == 8, q0.size() == 0, q0.size() >= 4, q0.size() <= 2, m0_ov, m0_un, m0_rv}
          || d0_level !== 4'(q0.size()) || d0_rd_data !== m0_rd) begin
        failed++;
        $display("FAIL rand_d0 n=%0d: got st %b lvl %0d data %h exp st %b lvl %0d data %h", n,
                 {d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un, d0_rv}, d0_level, d0_rd_data,
                 {q0.size() == 8, q0.size() == 0, q0.size() >= 4, q0.size() <= 2, m0_ov, m0_un, m0_rv},
                 q0.size(), m0_rd);
      end
      tests++;
      if ({d2_full, d2_empty, d2_af, d2_ae, d2_ov, d2_un, d2_rv} !==
          {q2.size() == 6, q2.size() == 0, q2.size() >= 5, q2.size() <= 1, m2_ov, m2_un, m2_rv}
          || d2_level !== 4'(q2.size()) || d2_rd_data !== m2_rd) begin
        failed++;
        $display("FAIL rand_d2 n=%0d: got st %b lvl %0d data %h exp st %b lvl %0d data %h", n,
                 {d2_full, d2_empty, d2_af, d2_ae, d2_ov, d2_un, d2_rv}, d2_level, d2_rd_data,
                 {q2.size() == 6, q2.size() == 0, q2.size() >= 5, q2.size() <= 1, m2_ov, m2_un, m2_rv},
                 q2.size(), m2_rd);
      end
      lvl1 = q1.size() + int'(m1_v);
      tests++;
      if ({d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un, d1_rv} !==
          {q1.size() == 8, !m1_v, lvl1 >= 6, lvl1 <= 1, m1_ov, m1_un, m1_v}
          || d1_level !== 4'(lvl1) || (m1_v && d1_rd_data !== m1_d)) begin
        failed++;
        $display("FAIL rand_d1 n=%0d: got st %b lvl %0d data %h exp st %b lvl %0d data %h", n,
                 {d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un, d1_rv}, d1_level, d1_rd_data,
                 {q1.size() == 8, !m1_v, lvl1 >= 6, lvl1 <= 1, m1_ov, m1_un, m1_v}, lvl1, m1_d);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(0, 0, '0, 1);
    for (int k = 0; k < 6; k++) tick(1, (k == 5), 16'h400 + 16'(k), 0);
    tests++;
    if (d0_level !== 4'd5 || d0_rv !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset: got level %0d rv %b exp 5 1", d0_level, d0_rv);
    end
    #2;
    rst = 1;
    #1;
    tests++;
    if ({d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un} !== 7'b0010100 ||
        d0_level !== 4'd0 || d0_rd_data !== 16'h0) begin
      failed++;
      $display("FAIL async_reset_d0: got st %b level %0d data %h exp 0010100 0 0000",
               {d0_rv, d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un}, d0_level, d0_rd_data);
    end
    tests++;
    if (d1_rv !== 1'b0 || d1_level !== 4'd0 || d1_empty !== 1'b1) begin
      failed++;
      $display("FAIL async_reset_d1: got rv %b level %0d empty %b exp 0 0 1", d1_rv, d1_level, d1_empty);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    tick(0, 1, '0, 0);
    tests++;
    if (d0_rv !== 1'b0 || d0_un !== 1'b1 || d0_level !== 4'd0) begin
      failed++;
      $display("FAIL post_reset_read: got rv %b un %b level %0d exp 0 1 0", d0_rv, d0_un, d0_level);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    test_reset();
    test_fill_drain();
    test_underflow_flush();
    test_fwft();
    test_wrap();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
